datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Clock  in  1  single clock; all registers update on rising edge.
REQ-002 Clear  in  1  asynchronous active-low reset.
REQ-003 PCout, Zhighout, Zlowout, MDRout, R6out, R7out  in  1 each  bus-source selects.
REQ-004 PCin, IRin, MARin, MDRin, Yin, R6in, R7in, HIin, LOin, ZHighIn, ZLowIn  in  1 each  register load enables.
REQ-005 IncPC  in  1  PC increment strobe.
REQ-006 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-007 op_code  in  5  ALU operation select.
REQ-008 Mdatain  in  32  memory read data.
REQ-009 lo_contents  out  32  current LO register value, continuous.
REQ-010 hi_contents  out  32  current HI register value, continuous.
REQ-011 Port order: PCout, Zlowout, Zhighout, MDRout, MARin, ZLowIn, ZHighIn, PCin, MDRin, Read, IRin, Yin, IncPC, LOin, HIin, op_code, Mdatain, R6in, R7in, R6out, R7out, Clear, Clock, lo_contents, hi_contents.

Function
REQ-012 Internal 32-bit registers: PC, IR, MAR, MDR, Y, R6, R7, HI, LO; 64-bit Z split into ZHigh[63:32] and ZLow[31:0].
REQ-013 32-bit bus combinational; priority when several outs asserted: MDRout > PCout > Zlowout > Zhighout > R6out > R7out; no out asserted -> bus = 0.
REQ-014 Each register loads from bus on rising edge while its in-signal is 1; otherwise holds.
REQ-015 MDR loads Mdatain when MDRin=1 and Read=1, bus when MDRin=1 and Read=0.
REQ-016 IncPC=1 -> PC <= PC+1 (mod 2^32); IncPC takes priority over PCin in the same cycle.
REQ-017 ALU combinational: A = Y, B = bus, result C[63:0]; ZHighIn loads C[63:32], ZLowIn loads C[31:0], independently.
REQ-018 Opcodes: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 SHR (logical, B[4:0]), 01000 SHL (B[4:0]), 01100 MUL, 01101 DIV, 01110 NEG (-B), 01111 NOT (~B); other codes -> C = 0.
REQ-019 ADD/SUB/AND/OR/SHR/SHL/NEG/NOT: C[31:0] = 32-bit result, carry discarded, C[63:32] = 0.
REQ-020 MUL: C = signed 64-bit product A*B.
REQ-021 DIV: signed, truncated toward zero; C[31:0] = quotient, C[63:32] = remainder (sign of dividend).
REQ-022 DIV by B=0: quotient 0, remainder A; no error signal.
REQ-023 Loading a register and reading it on the bus in the same cycle yields the old value on the bus.

Reset
REQ-024 Clear=0 asynchronously forces every register (PC, IR, MAR, MDR, Y, R6, R7, HI, LO, Z) to 0; lo_contents and hi_contents read 0.
REQ-025 Clear low mid-sequence aborts all loads; the first rising edge after Clear returns high performs normal operation.

Structure
REQ-026 Opcode constants (ADD..NOT) live in the shared cpu package, reused by the control unit.
REQ-027 ALU is one sub-module named alu (inputs A, B, op_code; output C[63:0]); registers, bus mux and MDR mux are in datapath.

Verification
REQ-028 Load R6=1637, R7=5877 via Mdatain/MDR; R6out+Yin; R7out, op_code=01100, ZLowIn+ZHighIn; Zlowout+LOin; Zhighout+HIin -> lo_contents=0x0092CCA9, hi_contents=0x00000000.
REQ-029 Same sequence with op_code=01101 -> lo_contents=0, hi_contents=1637.
REQ-030 Y=0xFFFFFFF9 (-7), B=2, DIV -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; Y=0xFFFFFFF8, B=2, MUL -> LO=0xFFFFFFF0, HI=0xFFFFFFFF.
REQ-031 DIV with B=0, Y=5 -> LO=0, HI=5.
REQ-032 PC=0xFFFFFFFF, IncPC=1 with PCin=1 -> PC=0; bus with MDRout and PCout both asserted carries MDR.
REQ-033 Assert Clear=0 between clock edges after loading HI/LO -> lo_contents and hi_contents become 0 immediately, before the next edge.

Source files
------------

// File: rtl/datapath_pkg.sv
// CPU-wide shared definitions: ALU opcode encodings and datapath widths.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// The control unit imports this package too, so the opcode values defined
// here are the single source of truth for both blocks.
package datapath_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned DWORD_W = 2 * WORD_W;

  // ALU operation select. Encodings not listed here make the ALU output zero.
  typedef enum logic [4:0] {
    OP_ADD = 5'b00011,
    OP_SUB = 5'b00100,
    OP_AND = 5'b00101,
    OP_OR  = 5'b00110,
    OP_SHR = 5'b00111,
    OP_SHL = 5'b01000,
    OP_MUL = 5'b01100,
    OP_DIV = 5'b01101,
    OP_NEG = 5'b01110,
    OP_NOT = 5'b01111
  } op_e;

  // Sign-extend a word to double width. Used to form the full signed product.
  function automatic logic [DWORD_W-1:0] sext_word(input logic [WORD_W-1:0] w);
    return {{WORD_W{w[WORD_W-1]}}, w};
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A (from Y) op B (from bus) -> 64-bit result C.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   A, B     32-bit operands (A = Y register, B = bus)
//   op_code  5-bit operation select (see datapath_pkg::op_e)
//   C        64-bit result; single-word ops leave C[63:32] = 0,
//            MUL gives the signed product, DIV gives {remainder, quotient}.
module alu
  import datapath_pkg::*;
(
  input  logic [WORD_W-1:0]  A,
  input  logic [WORD_W-1:0]  B,
  input  logic [4:0]         op_code,
  output logic [DWORD_W-1:0] C
);

  localparam logic [WORD_W-1:0] INT_MIN = {1'b1, {(WORD_W-1){1'b0}}};
  localparam logic [WORD_W-1:0] MINUS_1 = {WORD_W{1'b1}};

  logic [DWORD_W-1:0] product;
  logic [WORD_W-1:0]  quotient;
  logic [WORD_W-1:0]  remainder;
  logic signed [WORD_W-1:0] a_s;
  logic signed [WORD_W-1:0] b_s;

  assign a_s = $signed(A);
  assign b_s = $signed(B);

  // Low 64 bits of the product of the sign-extended operands equal the
  // two's-complement signed product, so an unsigned multiplier suffices.
  assign product = sext_word(A) * sext_word(B);

  // Signed division truncating toward zero, remainder takes the sign of
  // the dividend. Divide-by-zero returns quotient 0 and remainder A; the
  // single overflowing case (INT_MIN / -1) is pinned to a defined result
  // instead of relying on the simulator/synthesis treatment of overflow.
  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (B == '0) begin
      quotient  = '0;
      remainder = A;
    end else if (A == INT_MIN && B == MINUS_1) begin
      quotient  = INT_MIN;
      remainder = '0;
    end else begin
      quotient  = a_s / b_s;
      remainder = a_s % b_s;
    end
  end

  always_comb begin
    C = '0;
    case (op_code)
      OP_ADD:  C[WORD_W-1:0] = A + B;
      OP_SUB:  C[WORD_W-1:0] = A - B;
      OP_AND:  C[WORD_W-1:0] = A & B;
      OP_OR:   C[WORD_W-1:0] = A | B;
      OP_SHR:  C[WORD_W-1:0] = A >> B[4:0];
      OP_SHL:  C[WORD_W-1:0] = A << B[4:0];
      OP_MUL:  C = product;
      OP_DIV:  C = {remainder, quotient};
      OP_NEG:  C[WORD_W-1:0] = '0 - B;
      OP_NOT:  C[WORD_W-1:0] = ~B;
      default: C = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file slice, bus mux, MDR mux and ALU.
// Latency: register loads take effect on the rising Clock edge; bus and ALU are combinational.
// Backpressure: none; every load enable is honoured on the edge it is asserted.
//
// Ports:
//   *out (PCout, Zlowout, Zhighout, MDRout, R6out, R7out)  bus-source selects
//   *in  (PCin, IRin, MARin, MDRin, Yin, R6in, R7in, HIin, LOin,
//         ZHighIn, ZLowIn)                                  register load enables
//   IncPC        PC increment strobe, wins over PCin
//   Read         MDR source: 1 = Mdatain, 0 = bus
//   op_code      ALU operation select
//   Mdatain      memory read data
//   Clear        asynchronous active-low reset of every register
//   Clock        rising-edge clock
//   lo_contents  LO register, hi_contents  HI register (continuous)
module datapath
  import datapath_pkg::*;
(
  input  logic              PCout,
  input  logic              Zlowout,
  input  logic              Zhighout,
  input  logic              MDRout,
  input  logic              MARin,
  input  logic              ZLowIn,
  input  logic              ZHighIn,
  input  logic              PCin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              IRin,
  input  logic              Yin,
  input  logic              IncPC,
  input  logic              LOin,
  input  logic              HIin,
  input  logic [4:0]        op_code,
  input  logic [WORD_W-1:0] Mdatain,
  input  logic              R6in,
  input  logic              R7in,
  input  logic              R6out,
  input  logic              R7out,
  input  logic              Clear,
  input  logic              Clock,
  output logic [WORD_W-1:0] lo_contents,
  output logic [WORD_W-1:0] hi_contents
);

  logic [WORD_W-1:0]  pc;
  logic [WORD_W-1:0]  ir;
  logic [WORD_W-1:0]  mar;
  logic [WORD_W-1:0]  mdr;
  logic [WORD_W-1:0]  y;
  logic [WORD_W-1:0]  r6;
  logic [WORD_W-1:0]  r7;
  logic [WORD_W-1:0]  hi;
  logic [WORD_W-1:0]  lo;
  logic [WORD_W-1:0]  z_high;
  logic [WORD_W-1:0]  z_low;

  logic [WORD_W-1:0]  bus;
  logic [WORD_W-1:0]  mdr_d;
  logic [DWORD_W-1:0] alu_c;

  // IR and MAR feed the control unit and memory interface, which live
  // outside this slice; fold them here so they are visibly intentional.
  logic unused_regs;
  assign unused_regs = ^{ir, mar};

  // Bus source mux. Fixed priority resolves accidental multiple drivers
  // from the control unit; an idle bus reads zero.
  always_comb begin
    bus = '0;
    if (MDRout)
      bus = mdr;
    else if (PCout)
      bus = pc;
    else if (Zlowout)
      bus = z_low;
    else if (Zhighout)
      bus = z_high;
    else if (R6out)
      bus = r6;
    else if (R7out)
      bus = r7;
  end

  assign mdr_d = Read ? Mdatain : bus;

  alu u_alu (
    .A       (y),
    .B       (bus),
    .op_code (op_code),
    .C       (alu_c)
  );

  // Bus reads see the pre-edge register value, so a register may be driven
  // onto the bus and reloaded in the same cycle.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc     <= '0;
      ir     <= '0;
      mar    <= '0;
      mdr    <= '0;
      y      <= '0;
      r6     <= '0;
      r7     <= '0;
      hi     <= '0;
      lo     <= '0;
      z_high <= '0;
      z_low  <= '0;
    end else begin
      // Increment wins over a bus load so a fetch can always advance PC.
      if (IncPC)
        pc <= pc + 1'b1;
      else if (PCin)
        pc <= bus;

      if (IRin)    ir     <= bus;
      if (MARin)   mar    <= bus;
      if (MDRin)   mdr    <= mdr_d;
      if (Yin)     y      <= bus;
      if (R6in)    r6     <= bus;
      if (R7in)    r7     <= bus;
      if (HIin)    hi     <= bus;
      if (LOin)    lo     <= bus;
      if (ZHighIn) z_high <= alu_c[DWORD_W-1:WORD_W];
      if (ZLowIn)  z_low  <= alu_c[WORD_W-1:0];
    end
  end

  assign lo_contents = lo;
  assign hi_contents = hi;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic        PCout, Zlowout, Zhighout, MDRout, MARin, ZLowIn, ZHighIn, PCin;
  logic        MDRin, Read, IRin, Yin, IncPC, LOin, HIin;
  logic [4:0]  op_code;
  logic [31:0] Mdatain;
  logic        R6in, R7in, R6out, R7out;
  logic        Clear;
  logic        Clock;
  logic [31:0] lo_contents, hi_contents;

  int n_vec;
  int n_err;

  datapath dut (
    .PCout       (PCout),
    .Zlowout     (Zlowout),
    .Zhighout    (Zhighout),
    .MDRout      (MDRout),
    .MARin       (MARin),
    .ZLowIn      (ZLowIn),
    .ZHighIn     (ZHighIn),
    .PCin        (PCin),
    .MDRin       (MDRin),
    .Read        (Read),
    .IRin        (IRin),
    .Yin         (Yin),
    .IncPC       (IncPC),
    .LOin        (LOin),
    .HIin        (HIin),
    .op_code     (op_code),
    .Mdatain     (Mdatain),
    .R6in        (R6in),
    .R7in        (R7in),
    .R6out       (R6out),
    .R7out       (R7out),
    .Clear       (Clear),
    .Clock       (Clock),
    .lo_contents (lo_contents),
    .hi_contents (hi_contents)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    PCout = 0; Zlowout = 0; Zhighout = 0; MDRout = 0; MARin = 0;
    ZLowIn = 0; ZHighIn = 0; PCin = 0; MDRin = 0; Read = 0; IRin = 0;
    Yin = 0; IncPC = 0; LOin = 0; HIin = 0; op_code = 5'b0;
    Mdatain = 32'h0; R6in = 0; R7in = 0; R6out = 0; R7out = 0;
  endtask

  // Apply the currently driven controls across one rising edge, then drop them.
  task automatic step();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    step();
  endtask

  task automatic mdr_to_lo(input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1; LOin = 1;
    step();
  endtask

  // Y <= a, bus = b, run op into Z, then copy Z into LO/HI.
  task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    mem_to_mdr(a);
    MDRout = 1; Yin = 1;
    step();
    mem_to_mdr(b);
    MDRout = 1; op_code = op; ZLowIn = 1; ZHighIn = 1;
    step();
    Zlowout = 1; LOin = 1;
    step();
    Zhighout = 1; HIin = 1;
    step();
  endtask

  task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    alu_op(a, b, op);
    check({tag, ".lo"}, lo_contents, exp_lo);
    check({tag, ".hi"}, hi_contents, exp_hi);
  endtask

  // R6 = 1637 and R7 = 5877 loaded through MDR, then R6 -> Y, R7 on bus.
  task automatic r67_op(input logic [4:0] op);
    mem_to_mdr(32'd1637);
    MDRout = 1; R6in = 1;
    step();
    mem_to_mdr(32'd5877);
    MDRout = 1; R7in = 1;
    step();
    R6out = 1; Yin = 1;
    step();
    R7out = 1; op_code = op; ZLowIn = 1; ZHighIn = 1;
    step();
    Zlowout = 1; LOin = 1;
    step();
    Zhighout = 1; HIin = 1;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    Clear = 1'b1;

    // Reset held across edges with loads requested.
    #2 Clear = 1'b0;
    Mdatain = 32'hDEAD_BEEF; Read = 1; MDRin = 1; LOin = 1; HIin = 1;
    repeat (2) @(posedge Clock);
    #1;
    check("reset.lo", lo_contents, 32'h0);
    check("reset.hi", hi_contents, 32'h0);
    idle();
    Clear = 1'b1;

    // MDR load was aborted during reset; PC reset value is zero.
    MDRout = 1; LOin = 1;
    step();
    check("reset.mdr", lo_contents, 32'h0);
    mdr_to_lo(32'h1234_5678);
    check("mdr_lo", lo_contents, 32'h1234_5678);
    PCout = 1; LOin = 1;
    step();
    check("reset.pc", lo_contents, 32'h0);

    // Multiply and divide through R6/R7.
    r67_op(5'b01100);
    check("r67_mul.lo", lo_contents, 32'h0092_CCA9);
    check("r67_mul.hi", hi_contents, 32'h0000_0000);
    r67_op(5'b01101);
    check("r67_div.lo", lo_contents, 32'h0);
    check("r67_div.hi", hi_contents, 32'd1637);

    // R6 out wins over R7 out.
    R6out = 1; R7out = 1; LOin = 1;
    step();
    check("prio_r6_r7", lo_contents, 32'd1637);

    // Signed corner cases.
    alu_vec("div_neg",  32'hFFFF_FFF9, 32'd2, 5'b01101, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    alu_vec("mul_neg",  32'hFFFF_FFF8, 32'd2, 5'b01100, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    alu_vec("div_zero", 32'd5, 32'd0, 5'b01101, 32'h0, 32'd5);
    alu_vec("div_nd",   32'd7, 32'hFFFF_FFFE, 5'b01101, 32'hFFFF_FFFD, 32'd1);
    alu_vec("mul_nn",   32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'b01100, 32'd12, 32'h0);
    alu_vec("mul_big",  32'h0001_0000, 32'h0001_0000, 5'b01100, 32'h0, 32'd1);

    // Single-word operations.
    alu_vec("add",     32'd10, 32'd20, 5'b00011, 32'd30, 32'h0);
    alu_vec("add_ovf", 32'hFFFF_FFFF, 32'd1, 5'b00011, 32'h0, 32'h0);
    alu_vec("sub",     32'd5, 32'd7, 5'b00100, 32'hFFFF_FFFE, 32'h0);
    alu_vec("and",     32'hF0F0_FF00, 32'h0FF0_F0F0, 5'b00101, 32'h00F0_F000, 32'h0);
    alu_vec("or",      32'hF000_000F, 32'h0F00_00F0, 5'b00110, 32'hFF00_00FF, 32'h0);
    alu_vec("shr",     32'h8000_0000, 32'h0000_0024, 5'b00111, 32'h0800_0000, 32'h0);
    alu_vec("shl",     32'h0000_0001, 32'h0000_001F, 5'b01000, 32'h8000_0000, 32'h0);
    alu_vec("neg",     32'd99, 32'd5, 5'b01110, 32'hFFFF_FFFB, 32'h0);
    alu_vec("not",     32'd99, 32'h0000_FFFF, 5'b01111, 32'hFFFF_0000, 32'h0);
    alu_vec("bad_op",  32'd3, 32'd4, 5'b00000, 32'h0, 32'h0);

    // PC: increment beats a bus load, wraps to zero.
    mem_to_mdr(32'hFFFF_FFFF);
    MDRout = 1; PCin = 1;
    step();
    mem_to_mdr(32'h0000_0055);
    MDRout = 1; PCin = 1; IncPC = 1;
    step();
    PCout = 1; LOin = 1;
    step();
    check("pc_wrap", lo_contents, 32'h0);
    IncPC = 1;
    step();
    PCout = 1; LOin = 1;
    step();
    check("pc_inc", lo_contents, 32'h1);

    // MDR wins over PC; PC wins over Z low.
    MDRout = 1; PCout = 1; LOin = 1;
    step();
    check("prio_mdr_pc", lo_contents, 32'h0000_0055);
    PCout = 1; Zlowout = 1; HIin = 1;
    step();
    check("prio_pc_z", hi_contents, 32'h1);

    // Reload MDR while reading it: bus carries the old value.
    Mdatain = 32'hCAFE_0001; Read = 1; MDRin = 1; MDRout = 1; LOin = 1;
    step();
    check("old_on_bus", lo_contents, 32'h0000_0055);
    MDRout = 1; HIin = 1;
    step();
    check("mdr_new", hi_contents, 32'hCAFE_0001);

    // MDR from bus when Read = 0.
    PCout = 1; MDRin = 1; Read = 0;
    step();
    MDRout = 1; LOin = 1;
    step();
    check("mdr_from_bus", lo_contents, 32'h1);

    // Asynchronous clear between edges.
    alu_vec("pre_clr", 32'hFFFF_FFF8, 32'd2, 5'b01100, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    #2 Clear = 1'b0;
    #1;
    check("async_clr.lo", lo_contents, 32'h0);
    check("async_clr.hi", hi_contents, 32'h0);
    Mdatain = 32'h0000_00AA; Read = 1; MDRin = 1;
    @(posedge Clock);
    #1;
    idle();
    Clear = 1'b1;
    MDRout = 1; LOin = 1;
    step();
    check("clr_abort", lo_contents, 32'h0);
    mdr_to_lo(32'h0000_0077);
    check("post_clr", lo_contents, 32'h0000_0077);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
